// File: rtl/vx_gpu_pkg.sv
// Shared types for the GPU warp-control unit: op encoding, warp-control bus
// layout, barrier table entry and sizing constants.
package vx_gpu_pkg;

    localparam int NUM_WARPS    = 8;
    localparam int NUM_THREADS  = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int UUID_BITS    = 44;
    localparam int NW_BITS      = $clog2(NUM_WARPS);
    localparam int NT_BITS      = $clog2(NUM_THREADS);
    localparam int NB_BITS      = $clog2(NUM_BARRIERS);

    typedef enum logic [2:0] {
        GPU_TMC    = 3'd0,
        GPU_WSPAWN = 3'd1,
        GPU_BAR    = 3'd2,
        GPU_PRED   = 3'd3
    } gpu_op_e;

    typedef struct packed {
        logic                   valid;
        logic [NW_BITS-1:0]     wid;
        logic                   tmc_valid;
        logic [NUM_THREADS-1:0] tmc_mask;
        logic                   wspawn_valid;
        logic [NUM_WARPS-1:0]   wspawn_wmask;
        logic [31:0]            wspawn_pc;
        logic                   bar_stall;
        logic [NUM_WARPS-1:0]   bar_release;
    } wctl_t;

    // cnt is the number of warps already parked at the barrier.
    typedef struct packed {
        logic                 valid;
        logic [NW_BITS:0]     cnt;
        logic [NUM_WARPS-1:0] mask;
    } bar_entry_t;

    function automatic logic [NUM_WARPS-1:0] wid_onehot(input logic [NW_BITS-1:0] wid);
        logic [NUM_WARPS-1:0] oh;
        oh = '0;
        oh[wid] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/vx_gpu_barrier_table.sv
// Barrier table: tracks which warps are parked at each barrier and decides,
// per arrival, whether the barrier is satisfied (release) or the warp stalls.
module vx_gpu_barrier_table
    import vx_gpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arrive,
    input  logic [NB_BITS-1:0]   bar_id,
    input  logic [NW_BITS-1:0]   wid,
    input  logic [NW_BITS:0]     need,
    output logic                 stall,
    output logic [NUM_WARPS-1:0] rel_mask,
    output logic                 dup
);

    bar_entry_t           table_q [NUM_BARRIERS];
    bar_entry_t           entry;
    logic [NUM_WARPS-1:0] wbit;
    logic [NW_BITS+1:0]   arrived;
    logic                 meets;

    // Evaluate the arrival against the addressed entry.
    always_comb begin
        entry    = table_q[bar_id];
        wbit     = wid_onehot(wid);
        dup      = arrive && entry.valid && ((entry.mask & wbit) != '0);
        arrived  = {1'b0, entry.cnt} + (NW_BITS+2)'(1);
        meets    = arrived >= {1'b0, need};
        stall    = arrive && !dup && !meets;
        rel_mask = (arrive && !dup && meets) ? (entry.mask | wbit) : '0;
    end

    // Commit the arrival: clear on release, otherwise park the warp.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the table is a handful of flops and reset must forget every
            // parked warp, so each entry is cleared rather than left undefined.
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                table_q[i] <= '0;
            end
        end else if (arrive && !dup) begin
            if (meets) begin
                table_q[bar_id] <= '0;
            end else begin
                table_q[bar_id].valid <= 1'b1;
                table_q[bar_id].cnt   <= entry.cnt + (NW_BITS+1)'(1);
                table_q[bar_id].mask  <= entry.mask | wbit;
            end
        end
    end

    // A warp arriving twice at a barrier it is still parked on is a program error.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!dup);
        end
    end

endmodule

// File: rtl/vx_gpu_ctl_unit.sv
// Warp-control execute unit: decodes TMC/WSPAWN/BAR/PRED requests, drives a
// one-cycle warp-control pulse and returns a commit record one cycle later.
module vx_gpu_ctl_unit
    import vx_gpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    input  logic [UUID_BITS-1:0]     req_uuid,
    input  logic [NW_BITS-1:0]       req_wid,
    input  logic [NUM_THREADS-1:0]   req_tmask,
    input  logic [31:0]              req_PC,
    input  logic [31:0]              req_next_PC,
    input  logic [2:0]               req_op_type,
    input  logic [2:0]               req_op_mod,
    input  logic [NT_BITS-1:0]       req_tid,
    input  logic [NUM_THREADS*32-1:0] req_rs1_data,
    input  logic [NUM_THREADS*32-1:0] req_rs2_data,
    input  logic [4:0]               req_rd,
    input  logic                     req_wb,
    output logic                     req_ready,
    output logic                     wctl_valid,
    output logic [NW_BITS-1:0]       wctl_wid,
    output logic                     wctl_tmc_valid,
    output logic [NUM_THREADS-1:0]   wctl_tmc_mask,
    output logic                     wctl_wspawn_valid,
    output logic [NUM_WARPS-1:0]     wctl_wspawn_wmask,
    output logic [31:0]              wctl_wspawn_pc,
    output logic                     wctl_bar_stall,
    output logic [NUM_WARPS-1:0]     wctl_bar_release,
    output logic                     cmt_valid,
    input  logic                     cmt_ready,
    output logic [UUID_BITS-1:0]     cmt_uuid,
    output logic [NW_BITS-1:0]       cmt_wid,
    output logic [NUM_THREADS-1:0]   cmt_tmask,
    output logic [31:0]              cmt_PC,
    output logic [4:0]               cmt_rd,
    output logic                     cmt_wb
);

    logic                   accept;
    logic [31:0]            s1, s2;
    logic [NUM_THREADS-1:0] lane_pred, pred_mask;
    logic [NUM_WARPS-1:0]   spawn_mask;
    logic                   bar_arrive, bar_stall, bar_dup;
    logic [NUM_WARPS-1:0]   bar_rel;
    wctl_t                  wctl_d, wctl_q;
    logic                   unused_sigs;

    assign req_ready   = !cmt_valid || cmt_ready;
    assign accept      = req_valid && req_ready;
    assign bar_arrive  = accept && (req_op_type == GPU_BAR);
    assign unused_sigs = ^{req_op_mod, req_next_PC};

    vx_gpu_barrier_table u_bar (
        .clk      (clk),
        .reset_n  (reset_n),
        .arrive   (bar_arrive),
        .bar_id   (s1[NB_BITS-1:0]),
        .wid      (req_wid),
        .need     (s2[NW_BITS:0]),
        .stall    (bar_stall),
        .rel_mask (bar_rel),
        .dup      (bar_dup)
    );

    // Scalar operand selection, per-op masks and the next warp-control word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave a latch behind.
        s1     = '0;
        s2     = '0;
        wctl_d = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (req_tid == NT_BITS'(i)) begin
                s1 = req_rs1_data[i*32 +: 32];
                s2 = req_rs2_data[i*32 +: 32];
            end
            lane_pred[i] = req_rs1_data[i*32];
        end
        pred_mask = ((req_tmask & lane_pred) == '0) ? req_tmask : (req_tmask & lane_pred);
        for (int i = 0; i < NUM_WARPS; i++) begin
            spawn_mask[i] = (s1 >= 32'(NUM_WARPS)) || (32'(i) < s1);
        end
        spawn_mask[0] = 1'b0;

        wctl_d.wid = req_wid;
        case (req_op_type)
            GPU_TMC: begin
                wctl_d.valid     = 1'b1;
                wctl_d.tmc_valid = 1'b1;
                wctl_d.tmc_mask  = s1[NUM_THREADS-1:0];
            end
            GPU_PRED: begin
                wctl_d.valid     = 1'b1;
                wctl_d.tmc_valid = 1'b1;
                wctl_d.tmc_mask  = pred_mask;
            end
            GPU_WSPAWN: begin
                wctl_d.valid        = 1'b1;
                wctl_d.wspawn_valid = 1'b1;
                wctl_d.wspawn_wmask = spawn_mask;
                wctl_d.wspawn_pc    = s2;
            end
            GPU_BAR: begin
                wctl_d.valid       = !bar_dup;
                wctl_d.bar_stall   = bar_stall;
                wctl_d.bar_release = bar_rel;
            end
            default: ;
        endcase
    end

    // Output register: pulse warp control once per accept, hold commit until taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wctl_q    <= '0;
            cmt_valid <= 1'b0;
            cmt_uuid  <= '0;
            cmt_wid   <= '0;
            cmt_tmask <= '0;
            cmt_PC    <= '0;
            cmt_rd    <= '0;
            cmt_wb    <= 1'b0;
        end else if (accept) begin
            wctl_q    <= wctl_d;
            cmt_valid <= 1'b1;
            cmt_uuid  <= req_uuid;
            cmt_wid   <= req_wid;
            cmt_tmask <= req_tmask;
            cmt_PC    <= req_PC;
            cmt_rd    <= req_rd;
            cmt_wb    <= req_wb;
        end else begin
            wctl_q <= '0;
            if (cmt_ready) begin
                cmt_valid <= 1'b0;
            end
        end
    end

    assign wctl_valid        = wctl_q.valid;
    assign wctl_wid          = wctl_q.wid;
    assign wctl_tmc_valid    = wctl_q.tmc_valid;
    assign wctl_tmc_mask     = wctl_q.tmc_mask;
    assign wctl_wspawn_valid = wctl_q.wspawn_valid;
    assign wctl_wspawn_wmask = wctl_q.wspawn_wmask;
    assign wctl_wspawn_pc    = wctl_q.wspawn_pc;
    assign wctl_bar_stall    = wctl_q.bar_stall;
    assign wctl_bar_release  = wctl_q.bar_release;

endmodule

// File: tb/tb_vx_gpu_ctl_unit.sv
// Directed bench for the warp-control unit.
module tb_vx_gpu_ctl_unit;
    import vx_gpu_pkg::*;

    logic                      clk;
    logic                      reset_n;
    logic                      req_valid;
    logic [UUID_BITS-1:0]      req_uuid;
    logic [NW_BITS-1:0]        req_wid;
    logic [NUM_THREADS-1:0]    req_tmask;
    logic [31:0]               req_PC;
    logic [31:0]               req_next_PC;
    logic [2:0]                req_op_type;
    logic [2:0]                req_op_mod;
    logic [NT_BITS-1:0]        req_tid;
    logic [NUM_THREADS*32-1:0] req_rs1_data;
    logic [NUM_THREADS*32-1:0] req_rs2_data;
    logic [4:0]                req_rd;
    logic                      req_wb;
    logic                      req_ready;
    logic                      wctl_valid;
    logic [NW_BITS-1:0]        wctl_wid;
    logic                      wctl_tmc_valid;
    logic [NUM_THREADS-1:0]    wctl_tmc_mask;
    logic                      wctl_wspawn_valid;
    logic [NUM_WARPS-1:0]      wctl_wspawn_wmask;
    logic [31:0]               wctl_wspawn_pc;
    logic                      wctl_bar_stall;
    logic [NUM_WARPS-1:0]      wctl_bar_release;
    logic                      cmt_valid;
    logic                      cmt_ready;
    logic [UUID_BITS-1:0]      cmt_uuid;
    logic [NW_BITS-1:0]        cmt_wid;
    logic [NUM_THREADS-1:0]    cmt_tmask;
    logic [31:0]               cmt_PC;
    logic [4:0]                cmt_rd;
    logic                      cmt_wb;

    int checks   = 0;
    int failures = 0;

    vx_gpu_ctl_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_uuid          (req_uuid),
        .req_wid           (req_wid),
        .req_tmask         (req_tmask),
        .req_PC            (req_PC),
        .req_next_PC       (req_next_PC),
        .req_op_type       (req_op_type),
        .req_op_mod        (req_op_mod),
        .req_tid           (req_tid),
        .req_rs1_data      (req_rs1_data),
        .req_rs2_data      (req_rs2_data),
        .req_rd            (req_rd),
        .req_wb            (req_wb),
        .req_ready         (req_ready),
        .wctl_valid        (wctl_valid),
        .wctl_wid          (wctl_wid),
        .wctl_tmc_valid    (wctl_tmc_valid),
        .wctl_tmc_mask     (wctl_tmc_mask),
        .wctl_wspawn_valid (wctl_wspawn_valid),
        .wctl_wspawn_wmask (wctl_wspawn_wmask),
        .wctl_wspawn_pc    (wctl_wspawn_pc),
        .wctl_bar_stall    (wctl_bar_stall),
        .wctl_bar_release  (wctl_bar_release),
        .cmt_valid         (cmt_valid),
        .cmt_ready         (cmt_ready),
        .cmt_uuid          (cmt_uuid),
        .cmt_wid           (cmt_wid),
        .cmt_tmask         (cmt_tmask),
        .cmt_PC            (cmt_PC),
        .cmt_rd            (cmt_rd),
        .cmt_wb            (cmt_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] lanes(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Present one request, wait (bounded) for acceptance, and return at the
    // falling edge where the registered results are visible.
    task automatic send(input logic [2:0] op, input logic [NW_BITS-1:0] wid,
                        input logic [3:0] tmask, input logic [1:0] tid,
                        input logic [127:0] rs1, input logic [127:0] rs2,
                        input logic [43:0] uuid);
        int n;
        @(negedge clk);
        req_op_type  = op;
        req_wid      = wid;
        req_tmask    = tmask;
        req_tid      = tid;
        req_rs1_data = rs1;
        req_rs2_data = rs2;
        req_uuid     = uuid;
        req_PC       = 32'h1000 + 32'(uuid[7:0]);
        req_rd       = 5'(uuid[4:0]);
        req_wb       = uuid[0];
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [NUM_WARPS-1:0] rel_seen;

        reset_n = 1'b0; req_valid = 1'b0; cmt_ready = 1'b1;
        req_uuid = '0; req_wid = '0; req_tmask = '0; req_PC = '0; req_next_PC = 32'h4;
        req_op_type = '0; req_op_mod = '0; req_tid = '0; req_rs1_data = '0;
        req_rs2_data = '0; req_rd = '0; req_wb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmt_valid", 64'(cmt_valid), 64'd0);
        check("rst_wctl_valid", 64'(wctl_valid), 64'd0);
        check("rst_release", 64'(wctl_bar_release), 64'd0);
        check("rst_cmt_uuid", 64'(cmt_uuid), 64'd0);
        reset_n = 1'b1;

        // TMC: lead thread 2 carries 0x5
        send(3'd0, 3'd4, 4'hF, 2'd2, lanes(32'h0, 32'h0, 32'h5, 32'h0), '0, 44'h123);
        check("tmc_valid", 64'(wctl_valid), 64'd1);
        check("tmc_tvalid", 64'(wctl_tmc_valid), 64'd1);
        check("tmc_mask", 64'(wctl_tmc_mask), 64'h5);
        check("tmc_wid", 64'(wctl_wid), 64'd4);
        check("tmc_cmt_valid", 64'(cmt_valid), 64'd1);
        check("tmc_cmt_uuid", 64'(cmt_uuid), 64'h123);
        check("tmc_cmt_pc", 64'(cmt_PC), 64'h1023);
        check("tmc_cmt_rd", 64'(cmt_rd), 64'h03);
        check("tmc_cmt_wb", 64'(cmt_wb), 64'd1);
        @(negedge clk);
        check("tmc_pulse_end", 64'(wctl_valid), 64'd0);
        check("tmc_cmt_taken", 64'(cmt_valid), 64'd0);

        // PRED
        send(3'd3, 3'd1, 4'hF, 2'd0, lanes(32'h1, 32'h2, 32'h4, 32'h3), '0, 44'h200);
        check("pred_mask", 64'(wctl_tmc_mask), 64'h9);
        check("pred_tvalid", 64'(wctl_tmc_valid), 64'd1);
        send(3'd3, 3'd1, 4'hF, 2'd0, lanes(32'h0, 32'h2, 32'h0, 32'h0), '0, 44'h201);
        check("pred_zero_mask", 64'(wctl_tmc_mask), 64'hF);
        check("pred_cmt_tmask", 64'(cmt_tmask), 64'hF);

        // WSPAWN
        send(3'd1, 3'd0, 4'h1, 2'd0, lanes(32'd3, 0, 0, 0), lanes(32'h8000, 0, 0, 0), 44'h300);
        check("wspawn_valid", 64'(wctl_wspawn_valid), 64'd1);
        check("wspawn_wmask3", 64'(wctl_wspawn_wmask), 64'h06);
        check("wspawn_pc", 64'(wctl_wspawn_pc), 64'h8000);
        send(3'd1, 3'd0, 4'h1, 2'd1, lanes(0, 32'd20, 0, 0), lanes(0, 32'h40, 0, 0), 44'h301);
        check("wspawn_wmask20", 64'(wctl_wspawn_wmask), 64'hFE);
        check("wspawn_pc2", 64'(wctl_wspawn_pc), 64'h40);

        // BAR id1 need3: warps 0,2 stall, warp 5 releases
        send(3'd2, 3'd0, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd3, 0, 0, 0), 44'h400);
        check("bar_w0_stall", 64'(wctl_bar_stall), 64'd1);
        check("bar_w0_rel", 64'(wctl_bar_release), 64'h00);
        check("bar_w0_wid", 64'(wctl_wid), 64'd0);
        send(3'd2, 3'd2, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd3, 0, 0, 0), 44'h401);
        check("bar_w2_stall", 64'(wctl_bar_stall), 64'd1);
        check("bar_w2_rel", 64'(wctl_bar_release), 64'h00);
        send(3'd2, 3'd5, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd3, 0, 0, 0), 44'h402);
        check("bar_w5_stall", 64'(wctl_bar_stall), 64'd0);
        check("bar_w5_rel", 64'(wctl_bar_release), 64'h25);
        check("bar_w5_valid", 64'(wctl_valid), 64'd1);
        // entry cleared: need 1 releases only the arriving warp
        send(3'd2, 3'd3, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd1, 0, 0, 0), 44'h403);
        check("bar_reuse_rel", 64'(wctl_bar_release), 64'h08);
        check("bar_reuse_stall", 64'(wctl_bar_stall), 64'd0);
        // need 0 releases immediately on another barrier
        send(3'd2, 3'd6, 4'hF, 2'd0, lanes(32'd2, 0, 0, 0), lanes(32'd0, 0, 0, 0), 44'h404);
        check("bar_need0_rel", 64'(wctl_bar_release), 64'h40);

        // Illegal op: commit only
        send(3'd5, 3'd2, 4'h3, 2'd0, '0, '0, 44'h500);
        check("illegal_cmt", 64'(cmt_valid), 64'd1);
        check("illegal_wctl", 64'(wctl_valid), 64'd0);
        check("illegal_uuid", 64'(cmt_uuid), 64'h500);

        // Backpressure
        @(negedge clk);
        cmt_ready = 1'b0;
        send(3'd0, 3'd7, 4'hF, 2'd1, lanes(0, 32'h3, 0, 0), '0, 44'hABC);
        pulses = int'(wctl_valid);
        check("bp_cmt_valid0", 64'(cmt_valid), 64'd1);
        check("bp_ready0", 64'(req_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += int'(wctl_valid);
            check("bp_cmt_held", 64'(cmt_valid), 64'd1);
            check("bp_uuid_stable", 64'(cmt_uuid), 64'hABC);
            check("bp_ready_low", 64'(req_ready), 64'd0);
        end
        cmt_ready = 1'b1;
        @(negedge clk);
        check("bp_cmt_taken", 64'(cmt_valid), 64'd0);
        check("bp_pulses", 64'(pulses), 64'd1);

        // Reset with barrier 1 holding two warps
        send(3'd2, 3'd0, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd3, 0, 0, 0), 44'h600);
        send(3'd2, 3'd2, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd3, 0, 0, 0), 44'h601);
        check("rst2_pre_stall", 64'(wctl_bar_stall), 64'd1);
        reset_n = 1'b0;
        rel_seen = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rel_seen |= wctl_bar_release;
            check("rst2_wctl_valid", 64'(wctl_valid), 64'd0);
            check("rst2_cmt_valid", 64'(cmt_valid), 64'd0);
        end
        check("rst2_no_release", 64'(rel_seen), 64'h00);
        reset_n = 1'b1;
        send(3'd2, 3'd5, 4'hF, 2'd0, lanes(32'd1, 0, 0, 0), lanes(32'd3, 0, 0, 0), 44'h602);
        check("rst2_table_empty_stall", 64'(wctl_bar_stall), 64'd1);
        check("rst2_table_empty_rel", 64'(wctl_bar_release), 64'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
